// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and
// the default geometry of the table.
package btb_pkg;

    // Default table geometry: 2**INDEX_BITS entries, word-aligned PCs
    localparam int BTB_INDEX_BITS = 4;

    // Tag width left over after the index and the byte offset are removed
    function automatic int btb_tag_bits(input int index_bits);
        return 32 - index_bits - 2;
    endfunction

    // 2-bit saturating predictor states
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,   // strong not-taken
        CTR_WNT = 2'b01,   // weak not-taken
        CTR_WT  = 2'b10,   // weak taken
        CTR_ST  = 2'b11    // strong taken
    } ctr_t;

    // Freshly allocated entries start weakly taken
    localparam ctr_t CTR_ALLOC = CTR_WT;

    // Counters come out of reset weakly not-taken
    localparam ctr_t CTR_RESET = CTR_WNT;

endpackage

// File: rtl/btb_table_sat_counter2.sv
// 2-bit saturating counter next-state function (purely combinational).
module sat_counter2
    import btb_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_taken,
    output ctr_t o_ctr
);

    // Step one state toward taken or not-taken, holding at either end
    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            CTR_SNT: o_ctr = i_taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: o_ctr = i_taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  o_ctr = i_taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  o_ctr = i_taken ? CTR_ST  : CTR_WT;
            default: o_ctr = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer. Lookup is combinational from the
// current contents; EX-stage updates land on the rising clock edge. The
// table lives in registers so Reset can clear it asynchronously.
module btb_table
    import btb_pkg::*;
#(
    parameter int INDEX_BITS = BTB_INDEX_BITS,
    parameter int TAG_BITS   = btb_tag_bits(INDEX_BITS)
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] LookupPC,
    output logic        Hit,
    output logic        PredTaken,
    output logic [31:0] PredTarget,
    input  logic        UpdValid,
    input  logic [31:0] UpdPC,
    input  logic        UpdTaken,
    input  logic [31:0] UpdTarget,
    input  logic        Flush
);

    localparam int NUM_ENTRIES = 1 << INDEX_BITS;

    // Table storage
    logic                r_valid  [NUM_ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [NUM_ENTRIES];
    logic [31:0]         r_target [NUM_ENTRIES];
    ctr_t                r_ctr    [NUM_ENTRIES];

    // Lookup-side address split
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;

    // Update-side address split and hit detection
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic                  w_upd_hit;
    ctr_t                  w_upd_ctr_cur;
    ctr_t                  w_upd_ctr_next;
    logic [NUM_ENTRIES-1:0] w_upd_sel;

    // Byte-offset bits carry no information for word-aligned branches
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{LookupPC[1:0], UpdPC[1:0]};

    assign w_lk_idx  = LookupPC[INDEX_BITS+1:2];
    assign w_lk_tag  = LookupPC[31:INDEX_BITS+2];
    assign w_upd_idx = UpdPC[INDEX_BITS+1:2];
    assign w_upd_tag = UpdPC[31:INDEX_BITS+2];

    // Lookup reads the pre-update contents: no bypass from the update port
    always_comb begin
        Hit        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        PredTaken  = Hit && r_ctr[w_lk_idx][1];
        PredTarget = Hit ? r_target[w_lk_idx] : 32'h0;
    end

    // Resolve whether the branch being updated already owns its slot
    always_comb begin
        w_upd_hit     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_upd_ctr_cur = r_ctr[w_upd_idx];
    end

    // Single counter step on the update path, shared by all entries
    sat_counter2 u_sat_counter2 (
        .i_ctr   (w_upd_ctr_cur),
        .i_taken (UpdTaken),
        .o_ctr   (w_upd_ctr_next)
    );

    // Per-entry storage; each entry only reacts when the update targets it
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry

        assign w_upd_sel[gi] = UpdValid && (w_upd_idx == INDEX_BITS'(gi));

        // Reset clears everything; Flush drops valid bits and any update
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                r_valid[gi]  <= 1'b0;
                r_tag[gi]    <= '0;
                r_target[gi] <= 32'h0;
                r_ctr[gi]    <= CTR_RESET;
            end else if (Flush) begin
                r_valid[gi]  <= 1'b0;
            end else if (w_upd_sel[gi]) begin
                if (w_upd_hit) begin
                    // Train the resident entry; only taken outcomes move the target
                    r_ctr[gi] <= w_upd_ctr_next;
                    if (UpdTaken) begin
                        r_target[gi] <= UpdTarget;
                    end
                end else if (UpdTaken) begin
                    // Taken miss evicts whatever occupied the slot
                    r_valid[gi]  <= 1'b1;
                    r_tag[gi]    <= w_upd_tag;
                    r_target[gi] <= UpdTarget;
                    r_ctr[gi]    <= CTR_ALLOC;
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_table.sv
// Directed test of btb_table: reset, allocation, counter saturation,
// aliasing, same-cycle read-before-write, async reset and flush.
module tb_btb_table;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] LookupPC = 32'h0;
    logic        Hit;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        UpdValid = 1'b0;
    logic [31:0] UpdPC = 32'h0;
    logic        UpdTaken = 1'b0;
    logic [31:0] UpdTarget = 32'h0;
    logic        Flush = 1'b0;

    int total = 0;
    int bad   = 0;

    btb_table dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .LookupPC   (LookupPC),
        .Hit        (Hit),
        .PredTaken  (PredTaken),
        .PredTarget (PredTarget),
        .UpdValid   (UpdValid),
        .UpdPC      (UpdPC),
        .UpdTaken   (UpdTaken),
        .UpdTarget  (UpdTarget),
        .Flush      (Flush)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        LookupPC = pc;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        UpdValid  = 1'b1;
        UpdPC     = pc;
        UpdTaken  = taken;
        UpdTarget = tgt;
        tick();
        UpdValid  = 1'b0;
        $display("upd pc=%h taken=%0d tgt=%h", pc, taken, tgt);
    endtask

    task automatic check_lookup(input string tag, input logic [31:0] pc,
                                input logic hit, input logic pt, input logic [31:0] tgt);
        look(pc);
        $display("lookup %s pc=%h hit=%0d pt=%0d tgt=%h", tag, pc, Hit, PredTaken, PredTarget);
        chk({tag, "_hit"}, 32'(Hit), 32'(hit));
        chk({tag, "_pt"},  32'(PredTaken), 32'(pt));
        chk({tag, "_tgt"}, PredTarget, tgt);
    endtask

    initial begin
        // Reset state, visible while Reset is still high
        #2;
        check_lookup("rst_held", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        Reset = 1'b0;
        check_lookup("after_rst", 32'h0040_0010, 1'b0, 1'b0, 32'h0);

        // Allocate; the same-cycle lookup must still miss
        LookupPC  = 32'h0040_0010;
        UpdValid  = 1'b1; UpdPC = 32'h0040_0010; UpdTaken = 1'b1; UpdTarget = 32'h0040_0100;
        #1;
        chk("alloc_same_cycle_hit", 32'(Hit), 32'h0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        check_lookup("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);

        // 10 -> 01 -> 00 -> 00 -> 00; not-taken keeps the target
        upd(32'h0040_0010, 1'b0, 32'hDEAD_0000);
        check_lookup("nt1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
        upd(32'h0040_0010, 1'b0, 32'hDEAD_0001);
        upd(32'h0040_0010, 1'b0, 32'hDEAD_0002);
        upd(32'h0040_0010, 1'b0, 32'hDEAD_0003);
        check_lookup("nt4", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
        // From 00 a taken step reaches only 01 (no wrap to 11)
        upd(32'h0040_0010, 1'b1, 32'h0040_0104);
        check_lookup("sat_low", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0104);
        upd(32'h0040_0010, 1'b1, 32'h0040_0104);
        check_lookup("t_wt", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
        // 10 -> 11 -> 11, then one not-taken still predicts taken
        upd(32'h0040_0010, 1'b1, 32'h0040_0104);
        upd(32'h0040_0010, 1'b1, 32'h0040_0104);
        upd(32'h0040_0010, 1'b0, 32'h0);
        check_lookup("sat_high", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
        upd(32'h0040_0010, 1'b0, 32'h0);
        check_lookup("st_down2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0104);

        // Alias at the same index with a different tag evicts on taken
        upd(32'h0040_0050, 1'b1, 32'h0040_0200);
        check_lookup("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        check_lookup("alias_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);
        // A not-taken miss by the old PC must not evict
        upd(32'h0040_0010, 1'b0, 32'h0040_0999);
        check_lookup("alias_nt", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);

        // Not-taken on an empty index allocates nothing
        upd(32'h0040_0020, 1'b0, 32'h0040_0777);
        check_lookup("nt_empty", 32'h0040_0020, 1'b0, 1'b0, 32'h0);

        // Same-cycle lookup/update to a live entry returns the old target
        LookupPC  = 32'h0040_0050;
        UpdValid  = 1'b1; UpdPC = 32'h0040_0050; UpdTaken = 1'b1; UpdTarget = 32'h0040_0300;
        #1;
        chk("same_cycle_old_tgt", PredTarget, 32'h0040_0200);
        upd(32'h0040_0050, 1'b1, 32'h0040_0300);
        check_lookup("same_cycle_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300);

        // Several allocations, then Reset between edges
        upd(32'h0040_0020, 1'b1, 32'h0040_00A0);
        upd(32'h0040_0030, 1'b1, 32'h0040_00B0);
        check_lookup("pre_rst", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_00A0);
        UpdValid = 1'b1; UpdPC = 32'h0040_0080; UpdTaken = 1'b1; UpdTarget = 32'h0040_0888;
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_hit", 32'(Hit), 32'h0);
        chk("async_rst_tgt", PredTarget, 32'h0);
        tick();
        Reset = 1'b0;
        UpdValid = 1'b0;
        check_lookup("rst_20", 32'h0040_0020, 1'b0, 1'b0, 32'h0);
        check_lookup("rst_30", 32'h0040_0030, 1'b0, 1'b0, 32'h0);
        check_lookup("rst_inflight", 32'h0040_0080, 1'b0, 1'b0, 32'h0);
        check_lookup("rst_50", 32'h0040_0050, 1'b0, 1'b0, 32'h0);

        // Flush with a simultaneous taken update: all invalid, update dropped
        upd(32'h0040_0040, 1'b1, 32'h0040_0C00);
        upd(32'h0040_0060, 1'b1, 32'h0040_0D00);
        check_lookup("pre_flush", 32'h0040_0060, 1'b1, 1'b1, 32'h0040_0D00);
        Flush = 1'b1;
        upd(32'h0040_0070, 1'b1, 32'h0040_0E00);
        Flush = 1'b0;
        check_lookup("flush_40", 32'h0040_0040, 1'b0, 1'b0, 32'h0);
        check_lookup("flush_60", 32'h0040_0060, 1'b0, 1'b0, 32'h0);
        check_lookup("flush_upd", 32'h0040_0070, 1'b0, 1'b0, 32'h0);

        // Table still works after a flush
        upd(32'h0040_0070, 1'b1, 32'h0040_0F00);
        check_lookup("post_flush", 32'h0040_0070, 1'b1, 1'b1, 32'h0040_0F00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
